systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 150 +++++++++++++++
 tb/tb_systolic_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Systolic array feeder: skews input vectors across lanes and streams weight rows.
// Build option: define SYSTOLIC_FEEDER_STATS_EN to add the vec_count output
// (saturating count of accepted x vectors).
module systolic_feeder #(
  parameter int data_size = 16,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [data_size*size-1:0] x_in,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic [data_size*size-1:0] w_in,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [data_size*size-1:0] data_stream,
  output logic [data_size*size-1:0] w_stream,
  output logic                      set_w,
  output logic                      busy
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [15:0]               vec_count
`endif
);

  localparam int RW  = data_size * size;
  localparam int CW  = $clog2(size + 1);
  localparam int DRW = $clog2(2 * size);

  typedef enum logic [1:0] {IDLE, W_COLLECT, W_DRIVE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [DRW-1:0]  drain;
  logic [RW-1:0]   rows [size];
  logic [RW-1:0]   full [size];
  logic            x_fire, w_fire, last_row, drive_done;

  assign x_ready    = (state == IDLE);
  assign w_ready    = ((state == IDLE) && (drain == '0)) || (state == W_COLLECT);
  assign x_fire     = x_valid && x_ready;
  assign w_fire     = w_valid && w_ready;
  // cnt is zero in IDLE, so a single-row array completes on the first row
  assign last_row   = (cnt == CW'(size - 1));
  assign drive_done = (cnt == CW'(size));
  assign busy       = (state != IDLE) || (drain != '0);

  // Complete row set as it stands once the incoming row is appended
  always_comb begin
    for (int k = 0; k < size - 1; k++) full[k] = rows[k+1];
    full[size-1] = w_in;
  end

  // Next-state logic for the weight-load sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (w_fire) state_next = last_row ? W_DRIVE : W_COLLECT;
      W_COLLECT: if (w_fire && last_row) state_next = W_DRIVE;
      W_DRIVE:   if (drive_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Row store (shift-in while collecting, shift-out while driving) and registered weight outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < size; k++) rows[k] <= '0;
      cnt      <= '0;
      set_w    <= 1'b0;
      w_stream <= '0;
    end else begin
      case (state)
        IDLE, W_COLLECT: begin
          if (w_fire) begin
            if (last_row) begin
              w_stream <= full[0];
              set_w    <= 1'b1;
              for (int k = 0; k < size - 1; k++) rows[k] <= full[k+1];
              rows[size-1] <= '0;
              cnt      <= CW'(1);
            end else begin
              for (int k = 0; k < size; k++) rows[k] <= full[k];
              cnt <= cnt + 1'b1;
            end
          end
        end
        W_DRIVE: begin
          if (drive_done) begin
            set_w    <= 1'b0;
            w_stream <= '0;
            cnt      <= '0;
          end else begin
            w_stream <= rows[0];
            for (int k = 0; k < size - 1; k++) rows[k] <= rows[k+1];
            rows[size-1] <= '0;
            cnt      <= cnt + 1'b1;
          end
        end
        default: begin
          set_w    <= 1'b0;
          w_stream <= '0;
          cnt      <= '0;
        end
      endcase
    end
  end

  // Drain counter: tracks how long the last accepted vector stays in the skew pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          drain <= '0;
    else if (x_fire)     drain <= DRW'(2 * size - 1);
    else if (drain != 0) drain <= drain - 1'b1;
  end

  // Per-lane delay lines: lane r is delayed r extra cycles; idle cycles inject zeros
  for (genvar r = 0; r < size; r++) begin : g_lane
    logic [data_size-1:0] line [r+1];

    // Shift lane r every cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) line[k] <= '0;
      end else begin
        line[0] <= x_fire ? x_in[(size-r)*data_size-1 -: data_size] : '0;
        for (int k = 1; k <= r; k++) line[k] <= line[k-1];
      end
    end

    assign data_stream[(size-r)*data_size-1 -: data_size] = line[r];
  end

`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [15:0] vec_cnt;
  assign vec_count = vec_cnt;

  // Saturating count of accepted x vectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              vec_cnt <= '0;
    else if (x_fire && vec_cnt != 16'hFFFF) vec_cnt <= vec_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a queue-based reference model.
module tb_systolic_feeder;
  localparam int DSZ = 16;
  localparam int N   = 3;
  localparam int VW  = DSZ * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [VW-1:0] x_in = '0, w_in = '0;
  logic          x_valid = 1'b0, w_valid = 1'b0;
  logic          x_ready, w_ready, set_w, busy;
  logic [VW-1:0] data_stream, w_stream;
`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [15:0]   vec_count;
`endif

  systolic_feeder #(.data_size(DSZ), .size(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .w_in(w_in), .w_valid(w_valid), .w_ready(w_ready),
    .data_stream(data_stream), .w_stream(w_stream),
    .set_w(set_w), .busy(busy)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    , .vec_count(vec_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int            m_mode;      // 0 idle, 1 collecting, 2 driving
  int            m_drain;
  int            m_vecs;
  logic [VW-1:0] m_rows[$];
  logic [VW-1:0] m_hist[$];   // last N accepted-or-bubble vectors, newest at the back
  logic          m_set;
  logic [VW-1:0] m_ws;

  function automatic logic [DSZ-1:0] lane(input logic [VW-1:0] v, input int r);
    return v[(N-r)*DSZ-1 -: DSZ];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drain = 0; m_vecs = 0;
    m_rows.delete(); m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back('0);
    m_set = 1'b0; m_ws = '0;
  endtask

  task automatic step(input logic xv, input logic [VW-1:0] x, input logic wv, input logic [VW-1:0] w);
    logic xr, wr, xf, wf;
    logic [VW-1:0] exp_ds;
    @(negedge clk);
    x_valid = xv; x_in = x; w_valid = wv; w_in = w;
    xr = (m_mode == 0);
    wr = ((m_mode == 0) && (m_drain == 0)) || (m_mode == 1);
    check_eq("x_ready", x_ready, xr);
    check_eq("w_ready", w_ready, wr);
    xf = xv && xr;
    wf = wv && wr;
    @(posedge clk);
    m_hist.push_back(xf ? x : '0);
    void'(m_hist.pop_front());
    m_drain = xf ? 2*N-1 : (m_drain > 0 ? m_drain - 1 : 0);
    if (xf && m_vecs < 65535) m_vecs++;
    if (m_mode == 2) begin
      if (m_rows.size() > 0) begin m_ws = m_rows.pop_front(); m_set = 1'b1; end
      else begin m_mode = 0; m_set = 1'b0; m_ws = '0; end
    end else if (wf) begin
      m_rows.push_back(w);
      if (m_rows.size() == N) begin m_mode = 2; m_ws = m_rows.pop_front(); m_set = 1'b1; end
      else m_mode = 1;
    end
    #1;
    for (int r = 0; r < N; r++) exp_ds[(N-r)*DSZ-1 -: DSZ] = lane(m_hist[N-1-r], r);
    check_eq("data_stream", data_stream, exp_ds);
    check_eq("set_w", set_w, m_set);
    check_eq("w_stream", w_stream, m_ws);
    check_eq("busy", busy, (m_mode != 0) || (m_drain != 0));
`ifdef SYSTOLIC_FEEDER_STATS_EN
    check_eq("vec_count", vec_count, m_vecs);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; x_valid = 1'b0; w_valid = 1'b0;
    #1;
    check_eq("rst_set_w", set_w, 1'b0);
    check_eq("rst_w_stream", w_stream, '0);
    check_eq("rst_data_stream", data_stream, '0);
    check_eq("rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_x_ready", x_ready, 1'b1);
    check_eq("post_rst_w_ready", w_ready, 1'b1);
  endtask

  int highs;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_data_stream", data_stream, '0);
    check_eq("reset_w_stream", w_stream, '0);
    check_eq("reset_set_w", set_w, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    check_eq("reset_x_ready", x_ready, 1'b1);
    check_eq("reset_w_ready", w_ready, 1'b1);

    // Single vector walks diagonally across the lanes
    step(1'b1, {16'd1, 16'd2, 16'd3}, 1'b0, '0);
    check_eq("single_c1", data_stream, {16'd1, 16'd0, 16'd0});
    step(1'b0, '0, 1'b0, '0);
    check_eq("single_c2", data_stream, {16'd0, 16'd2, 16'd0});
    step(1'b0, '0, 1'b0, '0);
    check_eq("single_c3", data_stream, {16'd0, 16'd0, 16'd3});
    step(1'b0, '0, 1'b0, '0);
    check_eq("single_c4", data_stream, '0);
    idle(3);

    // Back-to-back vectors
    step(1'b1, {16'd1, 16'd2, 16'd3}, 1'b0, '0);
    step(1'b1, {16'd4, 16'd5, 16'd6}, 1'b0, '0);
    step(1'b1, {16'd7, 16'd8, 16'd9}, 1'b0, '0);
    check_eq("b2b_t3", data_stream, {16'd7, 16'd5, 16'd3});
    idle(6);

    // Weight rows with valid gaps
    step(1'b0, '0, 1'b1, {16'hA, 16'hB, 16'hC});
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, {16'hD, 16'hE, 16'hF});
    step(1'b0, '0, 1'b0, '0);
    highs = 0;
    step(1'b0, '0, 1'b1, {16'd1, 16'd2, 16'd3});
    if (set_w) highs++;
    check_eq("wrow0", w_stream, {16'hA, 16'hB, 16'hC});
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, '0);
      if (set_w) highs++;
    end
    check_eq("set_w_cycles", highs, 3);
    check_eq("w_idle_ready", w_ready, 1'b1);

    // Weight request right after a vector: held off while the pipe drains
    step(1'b1, {16'h11, 16'h22, 16'h33}, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, {16'h40 + 16'(i), 16'h50, 16'h60});
    check_eq("drain_then_collect", busy, 1'b1);

    // Reset during the second drive cycle
    do_reset();
    step(1'b0, '0, 1'b1, {16'h101, 16'h102, 16'h103});
    step(1'b0, '0, 1'b1, {16'h201, 16'h202, 16'h203});
    step(1'b0, '0, 1'b1, {16'h301, 16'h302, 16'h303});
    step(1'b0, '0, 1'b0, '0);
    check_eq("drive2_set_w", set_w, 1'b1);
    do_reset();
    // Fresh load after abort shows only the new rows
    step(1'b0, '0, 1'b1, {16'h7, 16'h8, 16'h9});
    step(1'b0, '0, 1'b1, {16'h6, 16'h5, 16'h4});
    step(1'b0, '0, 1'b1, {16'h3, 16'h2, 16'h1});
    check_eq("after_abort_row0", w_stream, {16'h7, 16'h8, 16'h9});
    idle(4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 119) == 0) do_reset();
      step($urandom_range(0, 99) < 50, {16'($urandom), 16'($urandom), 16'($urandom)},
           $urandom_range(0, 99) < 40, {16'($urandom), 16'($urandom), 16'($urandom)});
    end
    idle(8);

`ifdef SYSTOLIC_FEEDER_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, {16'(i), 16'(i), 16'(i)}, 1'b0, '0);
    check_eq("vec_count_5", vec_count, 16'd5);
    @(negedge clk);
    x_valid = 1'b0; w_valid = 1'b0;
    force dut.vec_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.vec_cnt;
    m_vecs = 65535;
    step(1'b1, {16'd1, 16'd1, 16'd1}, 1'b0, '0);
    check_eq("vec_count_sat", vec_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
